sr_cmd_sequencer: RTL and testbench

- Upstream stage of the SR flip-flop.
- Turns two raw, bouncy, asynchronous request lines (set request, reset request) into clean, registered, mutually exclusive s/r command pulses that feed the flip-flop's s and r inputs.
- Guarantees the flip-flop never sees {s,r}=2'b11, which is the undefined case of that flip-flop.
- Per-line flow: synchronise, debounce, rising-edge detect, then arbitrate and time each pulse through a small FSM.

---
 rtl/sr_cmd_pkg.sv | 32 +++
 rtl/sr_debounce.sv | 55 +++++
 rtl/sr_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR command sequencer.
// Holds the FSM state encoding, priority policy codes and status counter width.
// Helper functions are pure combinational and carry no state.
package sr_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SET_P = 2'b01,
      RST_P = 2'b10,
      HOLD  = 2'b11
   } state_t;

   // Simultaneous-request policy codes
   localparam int PRIO_RESET = 0;
   localparam int PRIO_SET   = 1;
   localparam int PRIO_DROP  = 2;

   localparam int STAT_W = 8;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Adds 0..2 to a status counter, pinning at all-ones instead of wrapping
   function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                 input logic [1:0]        inc);
      logic [STAT_W:0] sum;
      sum = {1'b0, a} + {{(STAT_W-1){1'b0}}, inc};
      return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
   endfunction

endpackage

// File: rtl/sr_debounce.sv
// Purpose: two-flop synchroniser, stable-sample debounce and rising-edge pulse for one raw line.
// Latency: req_o pulses DEBOUNCE_CYCLES+2 edges after a clean raw rise, for exactly one cycle.
// Backpressure: none; the pulse is fire-and-forget, the consumer decides whether to use it.
module sr_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic req_o
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          level_prev_q;
   logic [DW-1:0] cnt_q, cnt_d;

   // Debounce: count consecutive samples that disagree with the accepted level;
   // any agreeing sample restarts the count, so a bounce never accumulates.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchroniser chain, debounce state and previous level for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= raw_i;
         sync2_q      <= sync1_q;
         level_q      <= level_d;
         level_prev_q <= level_q;
         cnt_q        <= cnt_d;
      end
   end

   // Only the debounced 0->1 transition produces a request
   assign req_o = level_q & ~level_prev_q;

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Purpose: turns raw set/reset request lines into registered, mutually exclusive s/r pulses.
// Latency: s or r first reads 1 after DEBOUNCE_CYCLES+3 edges from a clean raw rise in IDLE.
// Backpressure: none; requests arriving while busy are dropped (counted when SR_CMD_STATUS_EN is defined).
module sr_cmd_sequencer
   import sr_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PULSE_CYCLES    = 1,
   parameter int HOLDOFF_CYCLES  = 2,
   parameter int PRIORITY        = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_req_raw,
   input  logic       rst_req_raw,
   output logic       s,
   output logic       r,
   output logic       busy,
   output logic       conflict,
   output logic [7:0] conflict_cnt,
   output logic [7:0] drop_cnt
);

   // One counter times both the pulse and the lockout, so size it for the longer
   localparam int CW = $clog2(max2(PULSE_CYCLES, HOLDOFF_CYCLES) + 1);
   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_CYCLES - 1);

   logic          set_req, rst_req;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          s_q, r_q, conflict_q;
   logic          s_d, r_d, conflict_d;

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_i (set_req_raw),
      .req_o (set_req)
   );

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_i (rst_req_raw),
      .req_o (rst_req)
   );

   // Next-state logic: arbitrate in IDLE, time the pulse, then the lockout
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      conflict_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (set_req && rst_req) begin
               if (PRIORITY == PRIO_RESET) begin
                  state_d = RST_P;
               end else if (PRIORITY == PRIO_SET) begin
                  state_d = SET_P;
               end else begin
                  conflict_d = 1'b1;
               end
            end else if (set_req) begin
               state_d = SET_P;
            end else if (rst_req) begin
               state_d = RST_P;
            end
         end
         SET_P, RST_P: begin
            if (cnt_q == PULSE_LAST) begin
               cnt_d   = '0;
               state_d = (HOLDOFF_CYCLES == 0) ? IDLE : HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they flip on the same edge as the FSM
   always_comb begin
      s_d = (state_d == SET_P);
      r_d = (state_d == RST_P);
   end

   // FSM, counter and registered command outputs; reset kills any pulse in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         s_q        <= s_d;
         r_q        <= r_d;
         conflict_q <= conflict_d;
      end
   end

   assign s        = s_q;
   assign r        = r_q;
   assign busy     = (state_q != IDLE);
   assign conflict = conflict_q;

`ifdef SR_CMD_STATUS_EN
   logic [STAT_W-1:0] conflict_cnt_q, drop_cnt_q;
   logic [1:0]        drop_inc;

   // Both request lines can be dropped in the same cycle, so the increment is 0..2
   always_comb begin
      drop_inc = 2'd0;
      if (state_q != IDLE) begin
         drop_inc = {1'b0, set_req} + {1'b0, rst_req};
      end
   end

   // Saturating status counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt_q <= '0;
         drop_cnt_q     <= '0;
      end else begin
         if (conflict_d) begin
            conflict_cnt_q <= sat_add(conflict_cnt_q, 2'd1);
         end
         drop_cnt_q <= sat_add(drop_cnt_q, drop_inc);
      end
   end

   assign conflict_cnt = conflict_cnt_q;
   assign drop_cnt     = drop_cnt_q;
`else
   assign conflict_cnt = 8'd0;
   assign drop_cnt     = 8'd0;
`endif

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Bench for sr_cmd_sequencer: four instances with different parameter sets, each with its own request lines.
// Expected s/r pulses are queued when stimulus is driven and popped as pulses complete.
// Status counter expectations follow SR_CMD_STATUS_EN.
module tb_sr_cmd_sequencer;

`ifdef SR_CMD_STATUS_EN
   localparam bit STAT_ON = 1'b1;
`else
   localparam bit STAT_ON = 1'b0;
`endif

   localparam int K_S = 1;
   localparam int K_R = 2;

   typedef struct {
      int dut;
      int kind;
      int len;
   } pulse_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] set_raw, rst_raw;
   logic [3:0] s_w, r_w, busy_w, conf_w;
   logic [7:0] ccnt_w [4];
   logic [7:0] dcnt_w [4];

   pulse_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int act [4];
   int kind[4];
   int len [4];
   int conf_cycles = 0;
   int c0;

   always #5 clk = ~clk;

   sr_cmd_sequencer #(.PRIORITY(0)) u_d0 (
      .clk(clk), .rst_n(rst_n), .set_req_raw(set_raw[0]), .rst_req_raw(rst_raw[0]),
      .s(s_w[0]), .r(r_w[0]), .busy(busy_w[0]), .conflict(conf_w[0]),
      .conflict_cnt(ccnt_w[0]), .drop_cnt(dcnt_w[0]));

   sr_cmd_sequencer #(.PRIORITY(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .set_req_raw(set_raw[1]), .rst_req_raw(rst_raw[1]),
      .s(s_w[1]), .r(r_w[1]), .busy(busy_w[1]), .conflict(conf_w[1]),
      .conflict_cnt(ccnt_w[1]), .drop_cnt(dcnt_w[1]));

   sr_cmd_sequencer #(.PRIORITY(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .set_req_raw(set_raw[2]), .rst_req_raw(rst_raw[2]),
      .s(s_w[2]), .r(r_w[2]), .busy(busy_w[2]), .conflict(conf_w[2]),
      .conflict_cnt(ccnt_w[2]), .drop_cnt(dcnt_w[2]));

   sr_cmd_sequencer #(.PULSE_CYCLES(3), .HOLDOFF_CYCLES(4), .PRIORITY(0)) u_d3 (
      .clk(clk), .rst_n(rst_n), .set_req_raw(set_raw[3]), .rst_req_raw(rst_raw[3]),
      .s(s_w[3]), .r(r_w[3]), .busy(busy_w[3]), .conflict(conf_w[3]),
      .conflict_cnt(ccnt_w[3]), .drop_cnt(dcnt_w[3]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int dut, input int k, input int l);
      pulse_t p;
      p.dut  = dut;
      p.kind = k;
      p.len  = l;
      exp_q.push_back(p);
   endtask

   // Model of the saturating status counter as seen on the port
   function automatic logic [31:0] exp_cnt(input int n);
      if (!STAT_ON) return 32'd0;
      return (n > 255) ? 32'd255 : 32'(n);
   endfunction

   // Pulse monitor: measures each s/r pulse and scores it against the queue
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) act[k] = 0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("s_r_exclusive_d%0d", k), {31'd0, s_w[k] & r_w[k]}, 32'd0);
            if (act[k] != 0) begin
               if ((kind[k] == K_S && s_w[k]) || (kind[k] == K_R && r_w[k])) begin
                  len[k]++;
               end else begin
                  pulse_t p;
                  act[k] = 0;
                  chk($sformatf("pulse_expected_d%0d", k), {31'd0, exp_q.size() > 0}, 32'd1);
                  if (exp_q.size() > 0) begin
                     p = exp_q.pop_front();
                     chk($sformatf("pulse_dut_d%0d", k), k, p.dut);
                     chk($sformatf("pulse_kind_d%0d", k), kind[k], p.kind);
                     chk($sformatf("pulse_len_d%0d", k), len[k], p.len);
                  end
               end
            end
            if (act[k] == 0 && (s_w[k] || r_w[k])) begin
               act[k]  = 1;
               kind[k] = s_w[k] ? K_S : K_R;
               len[k]  = 1;
            end
         end
         if (conf_w[2]) conf_cycles++;
      end
   end

   initial begin
      rst_n   = 1'b0;
      set_raw = 4'd0;
      rst_raw = 4'd0;
      tick(3);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_s_d%0d", k), {31'd0, s_w[k]}, 32'd0);
         chk($sformatf("rst_r_d%0d", k), {31'd0, r_w[k]}, 32'd0);
         chk($sformatf("rst_busy_d%0d", k), {31'd0, busy_w[k]}, 32'd0);
         chk($sformatf("rst_conflict_d%0d", k), {31'd0, conf_w[k]}, 32'd0);
         chk($sformatf("rst_ccnt_d%0d", k), {24'd0, ccnt_w[k]}, 32'd0);
         chk($sformatf("rst_dcnt_d%0d", k), {24'd0, dcnt_w[k]}, 32'd0);
      end
      rst_n = 1'b1;
      tick(3);

      // Clean set on the default instance: s after exactly 7 edges, busy for 3 cycles
      set_raw[0] = 1'b1;
      push(0, K_S, 1);
      tick(6);
      chk("lat_s_before", {31'd0, s_w[0]}, 32'd0);
      tick(1);
      chk("lat_s_at7", {31'd0, s_w[0]}, 32'd1);
      chk("lat_r_at7", {31'd0, r_w[0]}, 32'd0);
      chk("busy_c1", {31'd0, busy_w[0]}, 32'd1);
      tick(1);
      chk("s_one_cycle", {31'd0, s_w[0]}, 32'd0);
      chk("busy_c2", {31'd0, busy_w[0]}, 32'd1);
      tick(1);
      chk("busy_c3", {31'd0, busy_w[0]}, 32'd1);
      tick(1);
      chk("busy_c4_idle", {31'd0, busy_w[0]}, 32'd0);
      set_raw[0] = 1'b0;
      tick(10);

      // Bounce: 1,0,1,0 then steady 1; timing restarts from the final rise
      set_raw[0] = 1'b1; tick(1);
      set_raw[0] = 1'b0; tick(1);
      set_raw[0] = 1'b1; tick(1);
      set_raw[0] = 1'b0; tick(1);
      set_raw[0] = 1'b1;
      push(0, K_S, 1);
      tick(6);
      chk("bounce_s_before", {31'd0, s_w[0]}, 32'd0);
      tick(1);
      chk("bounce_s_at7", {31'd0, s_w[0]}, 32'd1);
      tick(4);
      set_raw[0] = 1'b0;
      tick(10);

      // Simultaneous rise on the three priority variants
      c0 = conf_cycles;
      set_raw[2:0] = 3'b111;
      rst_raw[2:0] = 3'b111;
      push(0, K_R, 1);
      push(1, K_S, 1);
      tick(7);
      chk("prio0_r", {31'd0, r_w[0]}, 32'd1);
      chk("prio1_s", {31'd0, s_w[1]}, 32'd1);
      chk("prio2_conflict", {31'd0, conf_w[2]}, 32'd1);
      chk("prio2_idle", {31'd0, busy_w[2]}, 32'd0);
      chk("prio2_s", {31'd0, s_w[2]}, 32'd0);
      chk("prio2_r", {31'd0, r_w[2]}, 32'd0);
      tick(1);
      chk("prio2_conflict_end", {31'd0, conf_w[2]}, 32'd0);
      chk("prio2_ccnt", {24'd0, ccnt_w[2]}, exp_cnt(1));
      tick(3);
      set_raw[2:0] = 3'b000;
      rst_raw[2:0] = 3'b000;
      tick(10);
      chk("prio2_conflict_cycles", conf_cycles - c0, 32'd1);

      // Lockout: reset request lands while the 3-cycle set pulse runs
      set_raw[3] = 1'b1;
      push(3, K_S, 3);
      tick(1);
      rst_raw[3] = 1'b1;
      tick(6);
      chk("lock_s_start", {31'd0, s_w[3]}, 32'd1);
      tick(6);
      chk("lock_busy_hold_end", {31'd0, busy_w[3]}, 32'd1);
      tick(1);
      chk("lock_busy_idle", {31'd0, busy_w[3]}, 32'd0);
      chk("lock_dcnt", {24'd0, dcnt_w[3]}, exp_cnt(1));
      set_raw[3] = 1'b0;
      rst_raw[3] = 1'b0;
      tick(10);

      // Asynchronous reset in the middle of a set pulse
      set_raw[3] = 1'b1;
      tick(8);
      chk("mid_s_high", {31'd0, s_w[3]}, 32'd1);
      set_raw[3] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_s_async", {31'd0, s_w[3]}, 32'd0);
      chk("mid_busy_async", {31'd0, busy_w[3]}, 32'd0);
      tick(2);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         chk("no_resume", {30'd0, s_w[3], r_w[3]}, 32'd0);
      end

      // Conflict counter saturation on the drop-both instance
      c0 = conf_cycles;
      for (int i = 0; i < 300; i++) begin
         set_raw[2] = 1'b1;
         rst_raw[2] = 1'b1;
         tick(8);
         set_raw[2] = 1'b0;
         rst_raw[2] = 1'b0;
         tick(7);
      end
      chk("sat_ccnt", {24'd0, ccnt_w[2]}, exp_cnt(300));
      chk("sat_conflict_cycles", conf_cycles - c0, 32'd300);
      set_raw[2] = 1'b1;
      rst_raw[2] = 1'b1;
      tick(8);
      set_raw[2] = 1'b0;
      rst_raw[2] = 1'b0;
      tick(7);
      chk("sat_ccnt_hold", {24'd0, ccnt_w[2]}, exp_cnt(301));
      chk("sat_conflict_cycles2", conf_cycles - c0, 32'd301);
      chk("sat_no_drops", {24'd0, dcnt_w[2]}, 32'd0);

      tick(5);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
